// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - host/processor-side signal bundle for the instruction fetch sequencer
interface instr_fetch_sequencer_if #(
  parameter int AW = 4,
  parameter int CW = 8
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [8:0]    load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          stop;
  logic          done;
  logic          run;
  logic [8:0]    din;
  logic [AW-1:0] pc;
  logic          busy;
  logic          prog_done;
  logic          err;
  logic [CW-1:0] instr_count;

  modport master (
    output load_en, load_addr, load_data, prog_len, start, stop, done,
    input  run, din, pc, busy, prog_done, err, instr_count
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start, stop, done,
    output run, din, pc, busy, prog_done, err, instr_count
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - program RAM plus issue FSM that feeds the 9-bit bus processor
// Words go out on din with a one-cycle run pulse; mvi immediates follow in the next cycle.
module instr_fetch_sequencer #(
  parameter int          AW      = 4,
  parameter logic [2:0]  MVI_OP  = 3'b001,
  parameter int          TIMEOUT = 15,
  parameter int          CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_sequencer_if.slave bus
);
  localparam int          DEPTH    = 1 << AW;
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t        state, state_d;
  logic [AW:0]   ptr, ptr_d, ptr_inc;
  logic [AW:0]   len, len_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          err, err_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          ram_we;
  logic [8:0]    word;
  logic [8:0]    ram [DEPTH];

  // ptr is one bit wider than the address so a full-depth program ends cleanly
  assign word    = ram[ptr[AW-1:0]];
  assign ptr_inc = ptr + 1'b1;
  assign ram_we  = (state == S_IDLE) && bus.load_en && !bus.stop;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      len   <= '0;
      tmo   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      len   <= len_d;
      tmo   <= tmo_d;
      err   <= err_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    len_d   = len;
    tmo_d   = tmo;
    err_d   = err;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.load_en) begin
          len_d   = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
          ptr_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = (len_d == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = (&cnt) ? cnt : cnt + 1'b1;
        ptr_d   = ptr_inc;
        state_d = (word[8:6] == MVI_OP) ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        ptr_d = ptr_inc;
        if (bus.done) begin
          state_d = (ptr_inc >= len) ? S_FINISH : S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          tmo_d   = '0;
          state_d = (ptr >= len) ? S_FINISH : S_ISSUE;
        end else if (tmo == TMO_LAST) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // stop wins over everything but leaves the error flag and count for inspection
    if (bus.stop) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      tmo_d   = '0;
      len_d   = len;
      err_d   = err;
      cnt_d   = cnt;
    end
  end

  assign bus.run         = (state == S_ISSUE);
  assign bus.din         = ((state == S_ISSUE) || (state == S_IMM)) ? word : 9'd0;
  assign bus.pc          = ptr[AW-1:0];
  assign bus.busy        = (state != S_IDLE);
  assign bus.prog_done   = (state == S_FINISH);
  assign bus.err         = err;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - scoreboard bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
  localparam int AW    = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int K_RUN = 0;
  localparam int K_IMM = 1;
  localparam int K_FIN = 2;

  typedef struct {
    int         kind;
    logic [8:0] word;
    int         err;
    int         cnt;
    int         pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_sequencer_if #(.AW(AW), .CW(CW)) ifc();

  instr_fetch_sequencer #(
    .AW(AW), .MVI_OP(3'b001), .TIMEOUT(15), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] ram_m [DEPTH];
  int         dly [32];
  int         cyc = 0;
  int         run_cyc = 0;
  int         fin_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // reference: walk the program by the issue rules, deciding each instruction's fate from its Done delay
  function automatic void model(input int plen);
    int L, p, cnt, d, limit, e_err;
    logic mvi;
    exp_t e;
    L = (plen > DEPTH) ? DEPTH : plen;
    p = 0; cnt = 0; e_err = 0;
    while (p < L) begin
      e.kind = K_RUN; e.word = ram_m[p % DEPTH]; e.err = 0; e.cnt = 0; e.pc = 0;
      q.push_back(e);
      cnt = (cnt < 255) ? cnt + 1 : cnt;
      mvi = (ram_m[p % DEPTH][8:6] == 3'b001);
      d = dly[cnt-1];
      if (mvi) begin
        e.kind = K_IMM; e.word = ram_m[(p + 1) % DEPTH];
        q.push_back(e);
      end
      p += mvi ? 2 : 1;
      limit = mvi ? 16 : 15;
      if (d < 1 || d > limit) begin
        e_err = 1;
        break;
      end
    end
    e.kind = K_FIN; e.word = 9'd0; e.err = e_err; e.cnt = cnt; e.pc = p % DEPTH;
    q.push_back(e);
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a run, an immediate or a completion
  initial begin
    logic       prev_run;
    logic [8:0] prev_din;
    exp_t       e;
    prev_run = 1'b0;
    prev_din = 9'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_run = 1'b0;
        continue;
      end
      if (ifc.run) begin
        if (ifc.instr_count == 0) run_cyc = cyc;
        if (q.size() == 0) chk("unexpected_run", 1, 0);
        else begin
          e = q.pop_front();
          chk("run_kind", K_RUN, e.kind);
          chk("run_din", ifc.din, e.word);
        end
      end else if (prev_run && prev_din[8:6] == 3'b001) begin
        if (q.size() == 0) chk("unexpected_imm", 1, 0);
        else begin
          e = q.pop_front();
          chk("imm_kind", K_IMM, e.kind);
          chk("imm_din", ifc.din, e.word);
        end
      end else begin
        chk("din_zero", ifc.din, 0);
      end
      if (ifc.prog_done) begin
        fin_cyc = cyc;
        if (q.size() == 0) chk("unexpected_prog_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("fin_kind", K_FIN, e.kind);
          chk("fin_err", ifc.err, e.err);
          chk("fin_count", ifc.instr_count, e.cnt);
          chk("fin_pc", ifc.pc, e.pc);
          chk("fin_busy", ifc.busy, 1);
        end
      end
      prev_run = ifc.run;
      prev_din = ifc.din;
    end
  end

  // processor stand-in: Done arrives dly[i] cycles after the i-th Run; dly<1 means never
  initial begin
    int pend, ridx;
    pend = -1; ridx = 0;
    ifc.done = 1'b0;
    forever begin
      @(negedge clk);
      ifc.done = 1'b0;
      if (!rst_n || !ifc.busy) begin
        pend = -1; ridx = 0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) ifc.done = 1'b1;
      end
      if (ifc.run) begin
        pend = (dly[ridx] < 1) ? -1 : dly[ridx];
        ridx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      ifc.load_en = 1'b1; ifc.load_addr = i[3:0]; ifc.load_data = ram_m[i];
      tick();
    end
    ifc.load_en = 1'b0;
  endtask

  task automatic set_dly(input int d);
    for (int i = 0; i < 32; i++) dly[i] = d;
  endtask

  task automatic run_prog(input int plen, input string tag);
    int L;
    int seen;
    L = (plen > DEPTH) ? DEPTH : plen;
    model(plen);
    ifc.prog_len = plen[4:0];
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk({tag, "_run_latency"}, ifc.run, (L > 0) ? 1 : 0);
    chk({tag, "_done_latency"}, ifc.prog_done, (L == 0) ? 1 : 0);
    chk({tag, "_err_cleared"}, ifc.err, 0);
    seen = ifc.prog_done;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      tick();
      seen = ifc.prog_done;
    end
    chk({tag, "_finished"}, seen, 1);
    tick();
    chk({tag, "_idle_after"}, ifc.busy, 0);
    chk({tag, "_queue_drained"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    exp_t       e;
    logic [8:0] w;
    int         any;
    ifc.load_en = 1'b0; ifc.load_addr = '0; ifc.load_data = '0;
    ifc.prog_len = '0; ifc.start = 1'b0; ifc.stop = 1'b0;
    set_dly(2);

    // reset held with start asserted
    rst_n = 1'b0;
    ifc.start = 1'b1; ifc.prog_len = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_run", ifc.run, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_din", ifc.din, 0);
      chk("rst_pc", ifc.pc, 0);
      chk("rst_prog_done", ifc.prog_done, 0);
      chk("rst_err", ifc.err, 0);
      chk("rst_count", ifc.instr_count, 0);
    end
    ifc.start = 1'b0;
    rst_n = 1'b1;
    tick();

    // three plain instructions, Done two cycles after each Run
    for (int i = 0; i < DEPTH; i++) ram_m[i] = 9'd0;
    ram_m[0] = 9'o000; ram_m[1] = 9'o010; ram_m[2] = 9'o001;
    load_all();
    run_prog(3, "basic");
    chk("basic_count", ifc.instr_count, 3);
    chk("basic_err", ifc.err, 0);

    // mvi with Done arriving during the immediate cycle
    ram_m[0] = 9'o100; ram_m[1] = 9'd5;
    load_all();
    dly[0] = 1;
    run_prog(2, "mvi");
    chk("mvi_done_distance", fin_cyc - run_cyc, 2);
    chk("mvi_count", ifc.instr_count, 1);

    // timeout: no Done ever
    ram_m[0] = 9'o010; ram_m[1] = 9'o020; ram_m[2] = 9'o030;
    load_all();
    set_dly(-1);
    run_prog(3, "timeout");
    chk("timeout_distance", fin_cyc - run_cyc, 16);
    chk("timeout_err", ifc.err, 1);
    chk("timeout_pc", ifc.pc, 1);

    // stop while idle keeps the sticky error
    ifc.stop = 1'b1; tick(); ifc.stop = 1'b0;
    chk("idle_stop_err", ifc.err, 1);
    chk("idle_stop_busy", ifc.busy, 0);

    // load and start together: load wins, start dropped
    ifc.load_en = 1'b1; ifc.load_addr = 4'd2; ifc.load_data = 9'o070;
    ifc.start = 1'b1; ifc.prog_len = 5'd3;
    tick();
    ifc.load_en = 1'b0; ifc.start = 1'b0;
    ram_m[2] = 9'o070;
    chk("load_start_busy", ifc.busy, 0);
    chk("load_start_err", ifc.err, 1);
    tick();
    chk("load_start_still_idle", ifc.busy, 0);

    // stop in WAIT of the second instruction; a load while busy must not land
    ram_m[0] = 9'o011; ram_m[1] = 9'o012; ram_m[2] = 9'o013;
    load_all();
    set_dly(2); dly[1] = -1;
    e.kind = K_RUN; e.err = 0; e.cnt = 0; e.pc = 0;
    e.word = ram_m[0]; q.push_back(e);
    e.word = ram_m[1]; q.push_back(e);
    ifc.prog_len = 5'd3; ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    any = 0;
    for (int i = 0; i < 50 && any == 0; i++) begin
      tick();
      if (ifc.instr_count == 2 && !ifc.run && ifc.busy) any = 1;
    end
    chk("stop_reached_wait", any, 1);
    ifc.load_en = 1'b1; ifc.load_addr = 4'd1; ifc.load_data = 9'o777;
    tick();
    ifc.load_en = 1'b0;
    ifc.stop = 1'b1; tick(); ifc.stop = 1'b0;
    chk("stop_busy", ifc.busy, 0);
    chk("stop_err", ifc.err, 0);
    chk("stop_pc", ifc.pc, 0);
    chk("stop_queue", q.size(), 0);
    any = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.prog_done || ifc.busy) any = 1;
    end
    chk("stop_no_prog_done", any, 0);
    set_dly(2);
    run_prog(3, "after_stop");

    // empty program, then an oversize length that clamps to the full RAM
    run_prog(0, "empty");
    chk("empty_count", ifc.instr_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      w = 9'($urandom);
      if (w[8:6] == 3'b001) w[8:6] = 3'b000;
      ram_m[i] = w;
    end
    load_all();
    run_prog(20, "clamp");
    chk("clamp_count", ifc.instr_count, 16);

    // randomized programs with occasional Done-window boundaries
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 9'($urandom);
        if ($urandom_range(0, 2) == 0) w[8:6] = 3'b001;
        else if (w[8:6] == 3'b001) w[8:6] = 3'b010;
        ram_m[i] = w;
      end
      load_all();
      for (int i = 0; i < 32; i++) begin
        case ($urandom_range(0, 19))
          0:       dly[i] = 15;
          1:       dly[i] = 16;
          2:       dly[i] = 17;
          3:       dly[i] = -1;
          default: dly[i] = $urandom_range(1, 6);
        endcase
      end
      run_prog($urandom_range(0, 20), "random");
    end

    // asynchronous reset mid-program
    ram_m[0] = 9'o010; ram_m[1] = 9'o020;
    load_all();
    set_dly(-1);
    e.kind = K_RUN; e.word = ram_m[0]; e.err = 0; e.cnt = 0; e.pc = 0;
    q.push_back(e);
    ifc.prog_len = 5'd2; ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", ifc.busy, 0);
    chk("async_rst_pc", ifc.pc, 0);
    chk("async_rst_count", ifc.instr_count, 0);
    chk("async_rst_run", ifc.run, 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", ifc.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
